// File: rtl/fft_pkg.sv
// Shared FFT constants, types and helpers for the sample loader and the address generator.
package fft_pkg;
  localparam int LOG2N_DEF  = 10;
  localparam int N_DEF      = 1 << LOG2N_DEF;
  localparam int ADDR_W_DEF = 11;

  typedef logic [ADDR_W_DEF-1:0] fft_addr_t;
  typedef logic [LOG2N_DEF-2:0]  tw_idx_t;

  typedef enum logic [1:0] {IDLE, RUN, GAP, FIN} agen_state_e;

  // Reverses the low 'bits' bits of v; higher bits come back as zero.
  function automatic fft_addr_t bit_reverse(input fft_addr_t v, input int bits);
    fft_addr_t r;
    r = '0;
    for (int i = 0; i < bits; i++) r[i] = v[bits-1-i];
    return r;
  endfunction
endpackage

// File: rtl/fft_addr_gen_if.sv
// Butterfly request channel: operand addresses, twiddle index and stage, valid/ready.
interface fft_addr_gen_if #(
  parameter int LOG2N  = 10,
  parameter int ADDR_W = 11
);
  localparam int SW = $clog2(LOG2N);

  logic              bf_valid;
  logic              bf_ready;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic [LOG2N-2:0]  tw_idx;
  logic [SW-1:0]     stage;

  modport master (output bf_valid, addr_a, addr_b, tw_idx, stage, input bf_ready);
  modport slave  (input bf_valid, addr_a, addr_b, tw_idx, stage, output bf_ready);
endinterface

// File: rtl/fft_bf_index.sv
// Maps (stage, butterfly counter) to the two in-place operand addresses and the twiddle index.
module fft_bf_index
  import fft_pkg::*;
#(
  parameter int LOG2N  = LOG2N_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  localparam int SW    = $clog2(LOG2N),
  localparam int KW    = LOG2N - 1
) (
  input  logic [SW-1:0]     s,
  input  logic [KW-1:0]     k,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic [KW-1:0]     tw_idx
);
  logic [KW-1:0]    mask, pos, grp;
  logic [LOG2N-1:0] half, a;

  always_comb begin
    mask   = ~({KW{1'b1}} << s);
    pos    = k & mask;
    grp    = k >> s;
    half   = LOG2N'(1) << s;
    // group base is grp*2*half; pos < half so the OR never collides with it
    a      = (({1'b0, grp} << s) << 1) | {1'b0, pos};
    tw_idx = pos << (KW - int'(s));
    addr_a = ADDR_W'(a);
    addr_b = ADDR_W'(a + half);
  end
endmodule

// File: rtl/fft_addr_gen.sv
// Radix-2 DIT in-place FFT address sequencer with inter-stage drain gap.
// Optional FFT_AGEN_PERF_CNT_EN adds a saturating stall counter output.
module fft_addr_gen
  import fft_pkg::*;
#(
  parameter int LOG2N     = LOG2N_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int STAGE_GAP = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  fft_addr_gen_if.master  bf,
  output logic            busy,
  output logic            done
`ifdef FFT_AGEN_PERF_CNT_EN
  ,
  output logic [15:0]     stall_cnt
`endif
);
  localparam int SW = $clog2(LOG2N);
  localparam int KW = LOG2N - 1;
  localparam int GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;

  agen_state_e       state;
  logic [SW-1:0]     s_q, s_n;
  logic [KW-1:0]     k_q, k_n;
  logic [GW-1:0]     gap_q;
  logic              bf_valid;
  logic [ADDR_W-1:0] addr_a, addr_b, a_n, b_n;
  logic [KW-1:0]     tw_idx, tw_n;
  logic              hs, k_last, s_last, gap_end, load;

  assign hs      = bf_valid & bf.bf_ready;
  assign k_last  = &k_q;
  assign s_last  = (s_q == SW'(LOG2N-1));
  assign gap_end = (gap_q == GW'(STAGE_GAP-1));

  // Coordinates of the butterfly to present after this edge.
  always_comb begin
    s_n = '0;
    k_n = '0;
    case (state)
      RUN:     begin
        k_n = k_q + 1'b1;
        s_n = k_last ? s_q + 1'b1 : s_q;
      end
      GAP:     s_n = s_q + 1'b1;
      default: ;
    endcase
  end

  // Edges where a new butterfly is registered onto the outputs.
  always_comb begin
    load = 1'b0;
    case (state)
      IDLE:    load = start;
      RUN:     load = hs && !(k_last && (s_last || STAGE_GAP > 0));
      GAP:     load = gap_end && !s_last;
      default: load = 1'b0;
    endcase
  end

  fft_bf_index #(.LOG2N(LOG2N), .ADDR_W(ADDR_W)) u_idx (
    .s      (s_n),
    .k      (k_n),
    .addr_a (a_n),
    .addr_b (b_n),
    .tw_idx (tw_n)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      s_q      <= '0;
      k_q      <= '0;
      gap_q    <= '0;
      bf_valid <= 1'b0;
      addr_a   <= '0;
      addr_b   <= '0;
      tw_idx   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state    <= RUN;
          busy     <= 1'b1;
          bf_valid <= 1'b1;
        end
        RUN: if (hs && k_last && (s_last || STAGE_GAP > 0)) begin
          bf_valid <= 1'b0;
          gap_q    <= '0;
          if (STAGE_GAP > 0) state <= GAP;
          else begin
            state <= FIN;
            done  <= 1'b1;
          end
        end
        GAP: if (gap_end) begin
          if (s_last) begin
            state <= FIN;
            done  <= 1'b1;
          end else begin
            state    <= RUN;
            bf_valid <= 1'b1;
          end
        end else gap_q <= gap_q + 1'b1;
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      if (load || hs) k_q <= k_n;
      if (load) begin
        s_q    <= s_n;
        addr_a <= a_n;
        addr_b <= b_n;
        tw_idx <= tw_n;
      end
    end
  end

`ifdef FFT_AGEN_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || (state == IDLE && start)) stall_cnt <= '0;
    else if (bf_valid && !bf.bf_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
`endif

  assign bf.bf_valid = bf_valid;
  assign bf.addr_a   = addr_a;
  assign bf.addr_b   = addr_b;
  assign bf.tw_idx   = tw_idx;
  assign bf.stage    = s_q;
endmodule

// File: doc/fft_addr_gen.md
Name: fft_addr_gen

Overview:
- Downstream neighbour of the sample loader. The loader fills the 1024-entry sample RAM in bit-reversed address order, then asserts data_loaded.
- This block then sequences a radix-2 decimation-in-time in-place FFT over that RAM.
- Per butterfly it emits the two operand addresses and the twiddle index to the butterfly datapath, using a valid/ready handshake.
- Inserts a programmable drain gap between stages and pulses done at the end.

Parameters:
- LOG2N, 10: log2 of FFT length; N = 2**LOG2N.
- ADDR_W, 11: RAM address width; must be >= LOG2N; upper bits of addresses are driven 0.
- STAGE_GAP, 4: idle cycles inserted after the last butterfly of each stage, for datapath write-back drain.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous active-high
- start  in  1  begin transform; sampled only in IDLE (tie to loader's data_loaded)
- bf_valid  out  1  addr_a/addr_b/tw_idx/stage are valid
- bf_ready  in  1  datapath accepts the current butterfly
- addr_a  out  ADDR_W  upper-leg address
- addr_b  out  ADDR_W  lower-leg address
- tw_idx  out  LOG2N-1  twiddle ROM index
- stage  out  $clog2(LOG2N)  current stage number
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at end of transform

Behaviour:
- Reset values: bf_valid=0, addr_a=0, addr_b=0, tw_idx=0, stage=0, busy=0, done=0; FSM=IDLE; counters 0.
- rst asserted mid-transform aborts immediately to IDLE on the next edge; no done pulse.
- FSM states: IDLE, RUN, GAP, FIN.
- IDLE -> RUN: on the clock edge where start=1. start is level-sensitive, so a held start re-triggers after FIN. First butterfly is valid the cycle after that edge.
- Address formula in RUN, stage s in 0..LOG2N-1, butterfly counter k in 0..N/2-1:
  - half = 1<<s, pos = k & (half-1), grp = k >> s.
  - addr_a = grp*2*half + pos, addr_b = addr_a + half.
  - tw_idx = pos << (LOG2N-1-s).
- Outputs are registered, and bf_valid holds with all fields stable until bf_valid&&bf_ready.
- On handshake, k increments and the next butterfly is presented in the following cycle, with no bubble. Back-to-back throughput is 1 per cycle.
- bf_ready low stalls the block; fields stay frozen.
- On the handshake of k=N/2-1:
  - bf_valid drops next cycle.
  - If STAGE_GAP>0, go to GAP; the gap counter counts STAGE_GAP cycles.
  - If STAGE_GAP=0, go directly to the next stage with no bubble.
  - On the last stage, go to GAP and then FIN.
- GAP -> RUN with s+1 and k=0. The stage output updates on entering RUN.
- FIN: done=1 for exactly one cycle, busy=1, then IDLE with busy=0.
- Total butterflies: LOG2N*N/2 (5120 at defaults). Cycle count with no stalls: LOG2N*(N/2+STAGE_GAP)+2.
- Arithmetic:
  - k is LOG2N-1 bits and wraps to 0 at stage end.
  - Address math is LOG2N bits, zero-extended to ADDR_W.
  - tw_idx fits LOG2N-1 bits by construction.

Optional Feature:
- Macro: FFT_AGEN_PERF_CNT_EN.
- Defined:
  - Adds output stall_cnt [15:0], counting cycles with bf_valid=1 && bf_ready=0.
  - Cleared on rst and on IDLE->RUN; saturates at 16'hFFFF; holds its value after done.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package fft_pkg:
  - LOG2N_DEF and N_DEF constants.
  - typedef fft_addr_t (logic [ADDR_W-1:0]).
  - typedef tw_idx_t.
  - enum agen_state_e {IDLE, RUN, GAP, FIN}.
  - bit_reverse function, shared with the loader bench.
- One natural sub-module: fft_bf_index (combinational), mapping (s,k) to (addr_a, addr_b, tw_idx); its outputs are registered in the parent.

Test Plan:
- LOG2N=3, STAGE_GAP=0, bf_ready=1, start pulse -> 12 butterflies, then done 1 cycle:
  - s0 k=0: a=0, b=1, tw=0.
  - s1 k=1: a=1, b=3, tw=2.
  - s2 k=3: a=3, b=7, tw=3.
  - Total latency 14 cycles.
- LOG2N=3, STAGE_GAP=2 -> exactly 2 cycles with bf_valid=0 between stages; stage steps 0,1,2; done at cycle 20.
- Random bf_ready (50%) at defaults -> fields stable during stalls, 5120 handshakes, every (a,b) pair unique per stage, a^b==1<<s; with PERF macro, stall_cnt equals the bench's stall count.
- rst asserted at s=1, k=5 -> next cycle bf_valid=0, busy=0, stage=0, no done; a new start restarts at s0 k0.
- start held high through FIN -> second transform begins the cycle after IDLE is re-entered; start asserted while busy is ignored (no restart, counts unaffected).
